// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8
//   Receive-side time-division demultiplexer for the gate-test serial link.
//   Samples arrive one channel at a time. Channel 0 is marked by in_sync.
//   Samples are gathered in a shadow register. Once the last channel arrives,
//   the whole frame is published on out_bus together with a one-cycle
//   out_valid pulse. Framing errors raise a one-cycle sync_err pulse.
//
// Parameters
//   CHANNELS  samples per frame (2..16)
//   WIDTH     bits per sample
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [WIDTH]            sample, qualified by in_valid
//   in_valid   in   sample present this cycle
//   in_sync    in   sample is channel 0 (frame start)
//   out_bus    out  [CHANNELS*WIDTH]   last complete frame, channel k at k*WIDTH
//   out_valid  out  one-cycle pulse when out_bus shows a new frame
//   chan       out  [clog2(CHANNELS)]  channel index of the next accepted sample
//   sync_err   out  one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tdm_demux8 #(
    parameter  int CHANNELS = 8,
    parameter  int WIDTH    = 1,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_sync,
    output logic [CHANNELS*WIDTH-1:0]    out_bus,
    output logic                         out_valid,
    output logic [CW-1:0]                chan,
    output logic                         sync_err
);

    localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                          state_q;
    logic [CW-1:0]                   chan_q;
    // The last channel is never held in the shadow. It is merged straight
    // from in_data into the frame at the moment of completion.
    logic [(CHANNELS-1)*WIDTH-1:0]   shadow_q;
    logic [CHANNELS*WIDTH-1:0]       out_bus_q;
    logic                            out_valid_q;
    logic                            sync_err_q;

    // Complete frame as it would look if the current sample closes it.
    logic [CHANNELS*WIDTH-1:0]       frame_d;
    assign frame_d = {in_data, shadow_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            shadow_q    <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            // Both flags are pulses. By default they drop every cycle.
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;

            if (in_valid) begin
                case (state_q)
                    IDLE: begin
                        // Unsynced samples are discarded silently until
                        // the first frame start is seen.
                        if (in_sync) begin
                            shadow_q[WIDTH-1:0] <= in_data;
                            chan_q              <= CW'(1);
                            state_q             <= RECV;
                        end
                    end

                    RECV: begin
                        if (in_sync) begin
                            // A sync at chan 0 is the expected start. Anywhere
                            // else, the partial frame is dropped and a new
                            // frame starts with this sample.
                            if (chan_q != '0) begin
                                sync_err_q <= 1'b1;
                            end
                            shadow_q[WIDTH-1:0] <= in_data;
                            chan_q              <= CW'(1);
                        end else if (chan_q == '0) begin
                            // A frame start was expected but not marked.
                            // Fall back and hunt for sync.
                            sync_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end else if (chan_q == LAST_CHAN) begin
                            out_bus_q   <= frame_d;
                            out_valid_q <= 1'b1;
                            chan_q      <= '0;
                        end else begin
                            shadow_q[chan_q*WIDTH +: WIDTH] <= in_data;
                            chan_q                          <= chan_q + CW'(1);
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        chan_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign chan      = chan_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;

    logic       clk;
    logic       rst_n;

    // 8 channels x 1 bit
    logic       in8_data;
    logic       in8_valid;
    logic       in8_sync;
    logic [7:0] out8_bus;
    logic       out8_valid;
    logic [2:0] chan8;
    logic       err8;

    // 4 channels x 2 bits
    logic [1:0] in4_data;
    logic       in4_valid;
    logic       in4_sync;
    logic [7:0] out4_bus;
    logic       out4_valid;
    logic [1:0] chan4;
    logic       err4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    tdm_demux8 #(.CHANNELS(8), .WIDTH(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in8_data),
        .in_valid  (in8_valid),
        .in_sync   (in8_sync),
        .out_bus   (out8_bus),
        .out_valid (out8_valid),
        .chan      (chan8),
        .sync_err  (err8)
    );

    tdm_demux8 #(.CHANNELS(4), .WIDTH(2)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in4_data),
        .in_valid  (in4_valid),
        .in_sync   (in4_sync),
        .out_bus   (out4_bus),
        .out_valid (out4_valid),
        .chan      (chan4),
        .sync_err  (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic       d;
        logic [7:0] bus;
        logic       ov;
        logic [2:0] ch;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic s, input logic d,
                       input logic [7:0] bus, input logic ov,
                       input logic [2:0] ch, input logic err);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.bus = bus; t.ov = ov; t.ch = ch; t.err = err;
        vecs.push_back(t);
    endtask

    // Whole frame sent back to back. Bit k of val is channel k.
    task automatic add_frame(input logic [7:0] val, input logic [7:0] prev);
        for (int k = 0; k < 8; k++) begin
            add(1'b1, k == 0, val[k], (k == 7) ? val : prev, k == 7,
                3'((k + 1) % 8), 1'b0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle on the 8x1 instance. Drive on the falling edge, then sample
    // 1 time unit after the rising edge.
    task automatic step8(input logic v, input logic s, input logic d);
        @(negedge clk);
        in8_valid = v;
        in8_sync  = s;
        in8_data  = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step8_chk(input string tag, input logic v, input logic s, input logic d,
                             input logic [7:0] bus, input logic ov,
                             input logic [2:0] ch, input logic err);
        step8(v, s, d);
        chk({tag, ".bus"}, out8_bus, bus);
        chk({tag, ".valid"}, out8_valid, ov);
        chk({tag, ".chan"}, chan8, ch);
        chk({tag, ".err"}, err8, err);
        $display("txn %0d %s v=%0b s=%0b d=%0b -> bus=%02h ov=%0b ch=%0d err=%0b",
                 cyc, tag, v, s, d, out8_bus, out8_valid, chan8, err8);
    endtask

    initial begin
        logic [7:0] gframe [2];
        logic [7:0] gprev;
        int         gaps_f2;
        int         pulses;
        int         p_cyc [2];
        logic [1:0] w4 [4];
        logic [7:0] exp4;
        logic [1:0] ch4e;

        rst_n     = 1'b1;
        in8_valid = 1'b0; in8_sync = 1'b0; in8_data = 1'b0;
        in4_valid = 1'b0; in4_sync = 1'b0; in4_data = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.bus8", out8_bus, 8'h00);
        chk("rst.valid8", out8_valid, 1'b0);
        chk("rst.chan8", chan8, 3'd0);
        chk("rst.err8", err8, 1'b0);
        chk("rst.bus4", out4_bus, 8'h00);
        chk("rst.chan4", chan4, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // ---------------- vector table ----------------
        // Unsynced sample in IDLE is ignored.
        add(1, 0, 1, 8'h00, 0, 0, 0);
        // Basic frame 1,0,1,1,0,0,1,0 -> 8'b01001101.
        add(1, 1, 1, 8'h00, 0, 1, 0);
        add(1, 0, 0, 8'h00, 0, 2, 0);
        add(1, 0, 1, 8'h00, 0, 3, 0);
        add(1, 0, 1, 8'h00, 0, 4, 0);
        add(1, 0, 0, 8'h00, 0, 5, 0);
        add(1, 0, 0, 8'h00, 0, 6, 0);
        add(1, 0, 1, 8'h00, 0, 7, 0);
        add(1, 0, 0, 8'h4D, 1, 0, 0);
        // Sync without valid does nothing.
        add(0, 1, 1, 8'h4D, 0, 0, 0);
        // Back-to-back A5 then 3C.
        add_frame(8'hA5, 8'h4D);
        add_frame(8'h3C, 8'hA5);
        // Early sync after 4 samples.
        add(1, 1, 1, 8'h3C, 0, 1, 0);
        add(1, 0, 1, 8'h3C, 0, 2, 0);
        add(1, 0, 1, 8'h3C, 0, 3, 0);
        add(1, 0, 1, 8'h3C, 0, 4, 0);
        add(1, 1, 1, 8'h3C, 0, 1, 1);
        add(1, 0, 0, 8'h3C, 0, 2, 0);
        add(1, 0, 1, 8'h3C, 0, 3, 0);
        add(1, 0, 1, 8'h3C, 0, 4, 0);
        add(1, 0, 0, 8'h3C, 0, 5, 0);
        add(1, 0, 0, 8'h3C, 0, 6, 0);
        add(1, 0, 1, 8'h3C, 0, 7, 0);
        add(1, 0, 1, 8'hCD, 1, 0, 0);
        // Missing sync at chan 0, then IDLE ignores unsynced samples.
        add(1, 0, 1, 8'hCD, 0, 0, 1);
        add(1, 0, 1, 8'hCD, 0, 0, 0);
        add(1, 0, 0, 8'hCD, 0, 0, 0);
        add(0, 0, 0, 8'hCD, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step8_chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].s, vecs[i].d,
                      vecs[i].bus, vecs[i].ov, vecs[i].ch, vecs[i].err);
        end

        // ---------------- frames with random gaps ----------------
        gframe[0] = 8'hA5;
        gframe[1] = 8'h3C;
        gprev     = 8'hCD;
        gaps_f2   = 0;
        pulses    = 0;
        p_cyc[0]  = 0;
        p_cyc[1]  = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                int g;
                g = $urandom_range(0, 3);
                if (f == 1) gaps_f2 += g;
                for (int j = 0; j < g; j++) begin
                    step8_chk("gap.idle", 1'b0, 1'b1, 1'b1, gprev, 1'b0, 3'(k), 1'b0);
                end
                step8_chk("gap.smp", 1'b1, k == 0, gframe[f][k],
                          (k == 7) ? gframe[f] : gprev, k == 7, 3'((k + 1) % 8), 1'b0);
                if (out8_valid) begin
                    if (pulses < 2) p_cyc[pulses] = cyc;
                    pulses++;
                end
            end
            gprev = gframe[f];
        end
        chk("gap.pulses", pulses, 2);
        chk("gap.spacing", p_cyc[1] - p_cyc[0], 8 + gaps_f2);

        // ---------------- reset mid-frame ----------------
        step8_chk("mid.s0", 1, 1, 1, 8'h3C, 0, 1, 0);
        step8_chk("mid.s1", 1, 0, 1, 8'h3C, 0, 2, 0);
        step8_chk("mid.s2", 1, 0, 0, 8'h3C, 0, 3, 0);
        step8_chk("mid.s3", 1, 0, 1, 8'h3C, 0, 4, 0);
        step8_chk("mid.s4", 1, 0, 1, 8'h3C, 0, 5, 0);
        @(negedge clk);
        in8_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid.rst.bus", out8_bus, 8'h00);
        chk("mid.rst.valid", out8_valid, 1'b0);
        chk("mid.rst.chan", chan8, 3'd0);
        chk("mid.rst.err", err8, 1'b0);
        $display("txn %0d mid-frame reset -> bus=%02h ch=%0d", cyc, out8_bus, chan8);
        @(negedge clk) rst_n = 1'b1;
        step8_chk("post.nosync", 1, 0, 1, 8'h00, 0, 0, 0);
        step8_chk("post.sync", 1, 1, 1, 8'h00, 0, 1, 0);

        // ---------------- 4 channels x 2 bits ----------------
        w4[0] = 2'b11; w4[1] = 2'b01; w4[2] = 2'b10; w4[3] = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in4_valid = (k < 4);
            in4_sync  = (k == 0);
            in4_data  = (k < 4) ? w4[k] : 2'b00;
            @(posedge clk);
            #1;
            cyc++;
            exp4 = (k >= 3) ? 8'b00100111 : 8'h00;
            ch4e = (k < 4) ? 2'((k + 1) % 4) : 2'd0;
            chk("w4.bus", out4_bus, exp4);
            chk("w4.valid", out4_valid, k == 3);
            chk("w4.chan", chan4, ch4e);
            chk("w4.err", err4, 1'b0);
            $display("txn %0d w4 k=%0d -> bus=%02h ov=%0b ch=%0d err=%0b",
                     cyc, k, out4_bus, out4_valid, chan4, err4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Time-division demultiplexer at the receiving end of the gate-test serial link. The logic-unit/multiplexer side serializes per-function result samples onto one line. This block collects one sample per channel into a parallel frame and publishes the complete frame with a one-cycle valid pulse. It also flags framing errors so the bench or a downstream checker can resynchronize.

## Interface
- CHANNELS, 8: channels per frame; legal range 2..16.
- WIDTH, 1: bits per channel sample.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  channel sample; valid only when in_valid=1.
- in_valid  in  1  one sample presented this cycle.
- in_sync  in  1  qualifies the sample as channel 0 (frame start); ignored when in_valid=0.
- out_bus  out  CHANNELS*WIDTH  last complete frame; channel k at out_bus[k*WIDTH +: WIDTH].
- out_valid  out  1  single-cycle pulse, high in the cycle out_bus first shows a new frame.
- chan  out  clog2(CHANNELS)  index the next accepted sample will be written to.
- sync_err  out  1  single-cycle pulse on a framing error.

## Operation
- **Storage.**
  - Shadow register holds the partial frame.
  - out_bus holds the last complete frame and changes only on frame completion.
- **State machine: two states, IDLE and RECV.**
- **IDLE.**
  - in_valid=0: no action.
  - in_valid=1 with in_sync=0: sample discarded, no error.
  - in_valid=1 with in_sync=1: sample stored to shadow channel 0; chan becomes 1; state goes to RECV.
- **RECV, in_valid=1, chan=0, in_sync=1:** sample stored to channel 0; chan becomes 1.
- **RECV, in_valid=1, chan=0, in_sync=0:** sync_err pulses; sample discarded; state goes to IDLE; chan stays 0.
- **RECV, in_valid=1, 0<chan<CHANNELS-1, in_sync=0:** sample stored to shadow[chan]; chan increments.
- **RECV, in_valid=1, chan=CHANNELS-1, in_sync=0:** frame completes.
  - out_bus loads the shadow with this sample merged in.
  - out_valid pulses.
  - chan wraps to 0; state stays RECV.
- **RECV, in_valid=1, chan≠0, in_sync=1 (early sync):**
  - sync_err pulses.
  - Partial frame discarded; out_bus unchanged.
  - Sample stored as channel 0; chan becomes 1.
- **RECV, in_valid=0:** hold. There is no timeout, and gaps between samples are unlimited.
- **Shadow contents:** unspecified except for channels written in the current frame. Channels are never partially published.
- **Reset (any time, including mid-frame):**
  - Immediately forces IDLE and chan=0.
  - Clears the shadow and drives out_bus=0, out_valid=0, sync_err=0.
  - The partial frame is lost.

## Timing
- All outputs are registered; none depend combinationally on the inputs.
- Throughput: one sample per cycle, so back-to-back frames complete every CHANNELS cycles with in_valid held high.
- Latency, last sample to output: the sample accepted at edge N appears on out_bus after edge N, with out_valid high for exactly the cycle following edge N.
- out_valid and sync_err are never high in the same cycle.
- chan always reflects post-edge state and is readable the cycle after each acceptance.
- Reset release: the first in_valid&in_sync edge after rst_n rises is accepted. No synchronizer is required inside the block.

## Test plan
- **Reset values:** assert rst_n=0 mid-frame with chan=5. Required immediately: out_bus=8'h00, out_valid=0, sync_err=0, chan=0. After release, a sample without sync is ignored and chan stays 0.
- **Basic frame:** CHANNELS=8, WIDTH=1. Send bits 1,0,1,1,0,0,1,0 on consecutive cycles, sync on the first. Required: out_bus=8'b01001101 one cycle after the eighth sample, with a single out_valid pulse.
- **Back-to-back and gaps:**
  - Two frames 8'hA5 then 8'h3C with no gap: out_valid pulses exactly 8 cycles apart and out_bus steps A5→3C.
  - Repeat with random in_valid gaps: same values, with pulse spacing matching the accepted-sample count.
- **Early sync:** after 4 samples, send a sample with in_sync=1. Required:
  - sync_err pulses once; chan=1.
  - out_bus keeps its previous value.
  - The following 7 samples complete a frame whose channel 0 is the resync sample.
- **Missing sync:** after a completed frame, send in_valid=1 with in_sync=0 at chan=0. Required: sync_err pulses, the block returns to IDLE, and further unsynced samples produce no pulses and leave out_bus unchanged.
- **Width parameter:** CHANNELS=4, WIDTH=2. Send 2'b11, 2'b01, 2'b10, 2'b00. Required: out_bus=8'b00100111 with one out_valid pulse.
